out_periph_mem: RTL and testbench

OUT_PERIPH_MEM -- requirements
Module: out_periph_mem

---
 rtl/out_periph_mem.sv | 106 ++++++++++
 tb/tb_out_periph_mem.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/out_periph_mem.sv
// Memory-mapped peripheral window: word storage with byte/half/word load-store,
// driving LED, LCD and 7-segment outputs directly from fixed storage words.
module out_periph_mem #(
  parameter int unsigned ADDR_W = 5,
  parameter logic [15:0] BASE   = 16'h7000,
  parameter int unsigned N_HEX  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_lsu_addr,
  input  logic                 i_lsu_wren,
  input  logic                 i_lsu_rden,
  input  logic [1:0]           i_size,
  input  logic                 i_uns,
  input  logic [31:0]          i_st_data,
  output logic [31:0]          o_ld_data,
  output logic                 o_ld_valid,
  output logic                 o_err,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [7*N_HEX-1:0]   o_io_hex
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic              hit_c;
  logic              legal_c;
  logic [ADDR_W-1:0] idx_c;
  logic [1:0]        off_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       shifted_c;
  logic [31:0]       ld_word_c;
  logic              unused_c;

  assign unused_c = ^i_lsu_addr[31:16];

  // Address decode, lane enables, store-data replication and load extraction
  always_comb begin
    hit_c     = (i_lsu_addr[15:ADDR_W+2] == BASE[15:ADDR_W+2]);
    idx_c     = i_lsu_addr[ADDR_W+1:2];
    off_c     = i_lsu_addr[1:0];
    legal_c   = 1'b0;
    be_c      = 4'b0000;
    wdata_c   = '0;
    case (i_size)
      2'b00: begin
        legal_c = 1'b1;
        be_c    = 4'b0001 << off_c;
        wdata_c = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        legal_c = ~off_c[0];
        be_c    = 4'b0011 << off_c;
        wdata_c = {2{i_st_data[15:0]}};
      end
      2'b10: begin
        legal_c = (off_c == 2'b00);
        be_c    = 4'b1111;
        wdata_c = i_st_data;
      end
      default: ;
    endcase
    shifted_c = mem[idx_c] >> {off_c, 3'b000};
    case (i_size)
      2'b00:   ld_word_c = i_uns ? {24'b0, shifted_c[7:0]}
                                 : {{24{shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   ld_word_c = i_uns ? {16'b0, shifted_c[15:0]}
                                 : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: ld_word_c = shifted_c;
    endcase
  end

  // Storage and load/error response; reset wins over any coincident access
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      o_ld_data  <= '0;
      o_ld_valid <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_ld_valid <= hit_c && legal_c && i_lsu_rden;
      o_err      <= hit_c && !legal_c && (i_lsu_wren || i_lsu_rden);
      if (hit_c && legal_c && i_lsu_rden) o_ld_data <= ld_word_c;
      if (hit_c && legal_c && i_lsu_wren) begin
        for (int b = 0; b < 4; b++) begin
          if (be_c[b]) mem[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
        end
      end
    end
  end

  assign o_io_ledr = mem[0];
  assign o_io_ledg = mem[4];
  assign o_io_lcd  = mem[12];

  // Four digits per word starting at word 8, low 7 bits of each byte
  for (genvar k = 0; k < N_HEX; k++) begin : g_hex
    localparam int unsigned WORD = 8 + k / 4;
    localparam int unsigned LANE = k % 4;
    assign o_io_hex[7*k +: 7] = mem[WORD][8*LANE +: 7];
  end

endmodule

// File: tb/tb_out_periph_mem.sv
// Bench for out_periph_mem: default and wide (ADDR_W=6, N_HEX=16) instances on
// a shared bus, each compared against a byte-array model of the window.
module tb_out_periph_mem;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic         wren, rden;
  logic [1:0]   size;
  logic         uns;
  logic [31:0]  st_data;

  logic [31:0]  ld_data0, ledr0, ledg0, lcd0;
  logic         ld_valid0, err0;
  logic [55:0]  hex0;
  logic [31:0]  ld_data1, ledr1, ledg1, lcd1;
  logic         ld_valid1, err1;
  logic [111:0] hex1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  out_periph_mem dut0 (
    .i_clk(clk), .i_rst(rst), .i_lsu_addr(addr), .i_lsu_wren(wren),
    .i_lsu_rden(rden), .i_size(size), .i_uns(uns), .i_st_data(st_data),
    .o_ld_data(ld_data0), .o_ld_valid(ld_valid0), .o_err(err0),
    .o_io_ledr(ledr0), .o_io_ledg(ledg0), .o_io_lcd(lcd0), .o_io_hex(hex0)
  );

  out_periph_mem #(.ADDR_W(6), .BASE(16'h7000), .N_HEX(16)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_lsu_addr(addr), .i_lsu_wren(wren),
    .i_lsu_rden(rden), .i_size(size), .i_uns(uns), .i_st_data(st_data),
    .o_ld_data(ld_data1), .o_ld_valid(ld_valid1), .o_err(err1),
    .o_io_ledr(ledr1), .o_io_ledg(ledg1), .o_io_lcd(lcd1), .o_io_hex(hex1)
  );

  // Reference model: window as a byte array per instance
  logic [7:0]  mb [2][256];
  int          aw   [2] = '{5, 6};
  int          nhex [2] = '{8, 16};
  logic [31:0] exp_ld [2];
  bit          exp_valid [2];
  bit          exp_err [2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(int i, int w);
    return {mb[i][4*w+3], mb[i][4*w+2], mb[i][4*w+1], mb[i][4*w]};
  endfunction

  function automatic logic [127:0] mhex(int i);
    logic [127:0] h = '0;
    for (int k = 0; k < nhex[i]; k++) h[7*k +: 7] = mb[i][4*(8 + k/4) + k%4][6:0];
    return h;
  endfunction

  task automatic model_reset(input int i);
    for (int b = 0; b < 256; b++) mb[i][b] = 8'h00;
    exp_ld[i] = '0;
    exp_valid[i] = 1'b0;
    exp_err[i] = 1'b0;
  endtask

  task automatic model_step(input int i, input bit wr, input bit rd, input logic [1:0] sz,
                            input bit u, input logic [31:0] a, input logic [31:0] d);
    int span, a16, n, ofs;
    bit hit, legal;
    logic [31:0] val;
    span = 4 << aw[i];
    a16  = int'(a[15:0]);
    hit  = (a16 >= 'h7000) && (a16 < 'h7000 + span);
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    legal = (sz != 2'd3) && (a16 % n == 0);
    exp_valid[i] = 1'b0;
    exp_err[i]   = 1'b0;
    if (!hit || !(wr || rd)) return;
    if (!legal) begin
      exp_err[i] = 1'b1;
      return;
    end
    ofs = a16 - 'h7000;
    if (rd) begin
      val = '0;
      for (int b = 0; b < n; b++) val = val | (32'(mb[i][ofs+b]) << (8*b));
      if (!u && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      exp_ld[i] = val;
      exp_valid[i] = 1'b1;
    end
    if (wr) for (int b = 0; b < n; b++) mb[i][ofs+b] = d[8*b +: 8];
  endtask

  task automatic check_all();
    check("ld_valid0", ld_valid0, exp_valid[0]);
    check("err0",      err0,      exp_err[0]);
    check("ld_data0",  ld_data0,  exp_ld[0]);
    check("ledr0",     ledr0,     mword(0, 0));
    check("ledg0",     ledg0,     mword(0, 4));
    check("lcd0",      lcd0,      mword(0, 12));
    check("hex0",      hex0,      mhex(0));
    check("ld_valid1", ld_valid1, exp_valid[1]);
    check("err1",      err1,      exp_err[1]);
    check("ld_data1",  ld_data1,  exp_ld[1]);
    check("ledr1",     ledr1,     mword(1, 0));
    check("ledg1",     ledg1,     mword(1, 4));
    check("lcd1",      lcd1,      mword(1, 12));
    check("hex1",      hex1,      mhex(1));
  endtask

  // One bus cycle: drive, take the edge, advance the model, compare everything
  task automatic do_op(input bit rst_lo, input bit wr, input bit rd, input logic [1:0] sz,
                       input bit u, input logic [31:0] a, input logic [31:0] d);
    rst = ~rst_lo; wren = wr; rden = rd; size = sz; uns = u; addr = a; st_data = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst_lo) model_reset(i);
      else model_step(i, wr, rd, sz, u, a, d);
    end
    check_all();
    rst = 1'b1; wren = 1'b0; rden = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wren = 1'b0; rden = 1'b0; size = 2'd0; uns = 1'b0;
    addr = '0; st_data = '0;
    do_op(1, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    do_op(1, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    check("rst_ledr", ledr0, 32'h0);
    check("rst_hex1", hex1, 112'h0);

    do_op(0, 1, 0, 2'd2, 0, 32'h0000_7000, 32'hA5A5_1234);
    check("ledr_word", ledr0, 32'hA5A5_1234);
    do_op(0, 0, 1, 2'd2, 0, 32'h0000_7000, 32'h0);
    check("ld_word", ld_data0, 32'hA5A5_1234);
    check("ld_word_v", ld_valid0, 1'b1);

    do_op(0, 1, 0, 2'd0, 0, 32'h0000_7021, 32'h0000_008E);
    check("hex_digit1", hex0[13:7], 7'h0E);
    check("hex_digit0", hex0[6:0], 7'h00);
    do_op(0, 0, 1, 2'd0, 0, 32'h0000_7021, 32'h0);
    check("ld_byte_s", ld_data0, 32'hFFFF_FF8E);
    do_op(0, 0, 1, 2'd0, 1, 32'h0000_7021, 32'h0);
    check("ld_byte_u", ld_data0, 32'h0000_008E);

    do_op(0, 1, 0, 2'd1, 0, 32'h0000_7031, 32'hFFFF_FFFF);
    check("err_half", err0, 1'b1);
    check("lcd_keep", lcd0, 32'h0);
    do_op(0, 0, 1, 2'd3, 0, 32'h0000_7000, 32'h0);
    check("err_rsvd", err0, 1'b1);
    check("rsvd_nov", ld_valid0, 1'b0);

    do_op(0, 1, 0, 2'd2, 0, 32'h0000_8000, 32'h1111_1111);
    check("miss_ledr", ledr0, 32'hA5A5_1234);
    do_op(0, 0, 1, 2'd2, 0, 32'h0000_8000, 32'h0);
    check("miss_nov", ld_valid0, 1'b0);

    do_op(0, 1, 0, 2'd2, 0, 32'h0000_7010, 32'h3);
    do_op(0, 1, 1, 2'd2, 0, 32'h0000_7010, 32'h5);
    check("rbw_data", ld_data0, 32'h3);
    check("rbw_ledg", ledg0, 32'h5);

    do_op(0, 1, 0, 2'd0, 0, 32'h0000_702F, 32'h0000_005A);
    check("hex_dig15", hex1[111:105], 7'h5A);
    do_op(0, 1, 0, 2'd2, 0, 32'h0000_70FC, 32'hDEAD_BEEF);
    do_op(0, 0, 1, 2'd2, 0, 32'h0000_70FC, 32'h0);
    check("w63_rt", ld_data1, 32'hDEAD_BEEF);
    check("w63_miss0", ld_valid0, 1'b0);

    do_op(0, 0, 1, 2'd2, 0, 32'h0000_7000, 32'h0);
    do_op(1, 1, 1, 2'd2, 0, 32'h0000_7000, 32'h7777_7777);
    check("rst_valid", ld_valid0, 1'b0);
    check("rst_ld", ld_data0, 32'h0);
    do_op(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    check("rst_nopend", ld_valid0, 1'b0);

    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) < 8) a = 32'h0000_7000 + 32'($urandom_range(0, 255));
      else a = $urandom;
      do_op($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom), 2'($urandom),
            1'($urandom), a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
